// File: rtl/la_pkg.sv
// la_pkg: shared state encoding and default widths for the logic-analyzer RAM write path
package la_pkg;
  typedef enum logic [1:0] {
    LA_ARB_IDLE,
    LA_ARB_REQ,
    LA_ARB_XFER
  } la_arb_state_e;
  localparam int LA_RAM_ADDR_WIDTH = 29;
  localparam int LA_RAM_DATA_WIDTH = 128;
endpackage

// File: rtl/la_ram_write_arbiter_if.sv
// la_ram_write_arbiter_if: pod-side and RAM-side request/ack/burst signals of the write arbiter
interface la_ram_write_arbiter_if import la_pkg::*; #(
  parameter int NUM_PODS   = 2,
  parameter int ADDR_WIDTH = LA_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = LA_RAM_DATA_WIDTH
);
  localparam int GW = $clog2(NUM_PODS);
  logic                           ram_ready;
  logic [NUM_PODS-1:0]            pod_enable;
  logic [NUM_PODS-1:0]            pod_wr_en;
  logic [NUM_PODS-1:0]            pod_wr_valid;
  logic [NUM_PODS*ADDR_WIDTH-1:0] pod_wr_addr;
  logic [NUM_PODS*DATA_WIDTH-1:0] pod_wr_data;
  logic [NUM_PODS-1:0]            pod_wr_ack;
  logic                           ram_wr_en;
  logic                           ram_wr_valid;
  logic [ADDR_WIDTH-1:0]          ram_wr_addr;
  logic [DATA_WIDTH-1:0]          ram_wr_data;
  logic                           ram_wr_ack;
  logic [GW-1:0]                  grant_id;
  logic [NUM_PODS-1:0]            protocol_err;
  modport master (
    input  ram_ready, pod_enable, pod_wr_en, pod_wr_valid, pod_wr_addr, pod_wr_data, ram_wr_ack,
    output pod_wr_ack, ram_wr_en, ram_wr_valid, ram_wr_addr, ram_wr_data, grant_id, protocol_err
  );
  modport slave (
    output ram_ready, pod_enable, pod_wr_en, pod_wr_valid, pod_wr_addr, pod_wr_data, ram_wr_ack,
    input  pod_wr_ack, ram_wr_en, ram_wr_valid, ram_wr_addr, ram_wr_data, grant_id, protocol_err
  );
endinterface

// File: rtl/la_rr_picker.sv
// la_rr_picker: combinational round-robin select, req at ptr_i has highest priority then wraps upward
module la_rr_picker #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] j;
  assign valid_o = |req_i;
  // scan from lowest priority to highest so the last hit wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/la_ram_write_arbiter.sv
// la_ram_write_arbiter: merges NUM_PODS pod write ports into one RAM write port, whole bursts round robin
module la_ram_write_arbiter import la_pkg::*; #(
  parameter int NUM_PODS   = 2,
  parameter int ADDR_WIDTH = LA_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = LA_RAM_DATA_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input logic                clk_ram,
  input logic                rst,
  la_ram_write_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_PODS);
  localparam int CW = $clog2(BURST_LEN) + 1;
  la_arb_state_e         state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_PODS-1:0]   ack_q, err_q, own;
  logic                  pick_vld, vld_q, accept, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  la_rr_picker #(.N(NUM_PODS)) u_pick (
    .req_i  (bus.pod_wr_en & bus.pod_enable),
    .ptr_i  (rr_q),
    .valid_o(pick_vld),
    .idx_o  (pick_idx)
  );

  assign own    = NUM_PODS'(1) << grant_q;
  // in-flight beat counts toward the burst so beat BURST_LEN+1 is refused
  assign accept = state_q == LA_ARB_XFER && bus.pod_wr_valid[grant_q] && cnt_q + CW'(vld_q) < CW'(BURST_LEN);
  assign done   = state_q == LA_ARB_XFER && vld_q && cnt_q == CW'(BURST_LEN - 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    cnt_d = state_q == LA_ARB_XFER ? cnt_q + CW'(vld_q) : '0;
    case (state_q)
      LA_ARB_IDLE: if (bus.ram_ready && pick_vld) begin
        grant_d = pick_idx;
        state_d = LA_ARB_REQ;
      end
      LA_ARB_REQ: if (bus.ram_wr_ack) state_d = LA_ARB_XFER;
      default: if (done) begin
        state_d = LA_ARB_IDLE;
        rr_d = int'(grant_q) == NUM_PODS - 1 ? '0 : grant_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      state_q <= LA_ARB_IDLE;
      grant_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      vld_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      ack_q <= state_q == LA_ARB_REQ && bus.ram_wr_ack ? own : '0;
      err_q <= err_q | (bus.pod_wr_valid & ~(accept ? own : '0));
      vld_q <= accept;
      if (accept) begin
        addr_q <= bus.pod_wr_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        data_q <= bus.pod_wr_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ram_wr_en    = state_q == LA_ARB_REQ;
  assign bus.ram_wr_valid = vld_q;
  assign bus.ram_wr_addr  = addr_q;
  assign bus.ram_wr_data  = data_q;
  assign bus.pod_wr_ack   = ack_q;
  assign bus.grant_id     = grant_q;
  assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_la_ram_write_arbiter.sv
// tb_la_ram_write_arbiter: directed checks of a 2-pod/4-beat and a 4-pod/8-beat arbiter
module tb_la_ram_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NP = g ? 4 : 2;
    localparam int BL = g ? 8 : 4;
    localparam int AW = 29;
    localparam int DW = 128;
    la_ram_write_arbiter_if #(.NUM_PODS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    la_ram_write_arbiter #(.NUM_PODS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk_ram(clk),
      .rst    (rst),
      .bus    (bus)
    );
    int reqs[NP];
    int left[NP];
    int wait_c, ack_dly, run;
    logic [NP-1:0] inj;
    logic [31:0] a;
    logic [AW-1:0] beat_a[$];
    logic [DW-1:0] beat_d[$];
    int grants[$];
    int gids[$];
    int runs[$];
    // pod and RAM behaviour: pods burst after ack, RAM acks after ack_dly+1 cycles of ram_wr_en
    initial begin
      bus.ram_ready = 1'b1;
      bus.pod_enable = '1;
      bus.pod_wr_en = '0;
      bus.pod_wr_valid = '0;
      bus.pod_wr_addr = '0;
      bus.pod_wr_data = '0;
      bus.ram_wr_ack = 1'b0;
      inj = '0;
      ack_dly = 0;
      wait_c = 0;
      run = 0;
      foreach (reqs[i]) begin
        reqs[i] = 0;
        left[i] = 0;
      end
      forever begin
        @(posedge clk);
        #1;
        if (bus.ram_wr_valid) begin
          beat_a.push_back(bus.ram_wr_addr);
          beat_d.push_back(bus.ram_wr_data);
          run++;
        end else if (run > 0) begin
          runs.push_back(run);
          run = 0;
        end
        for (int i = 0; i < NP; i++) begin
          a = 32'(32'h100 * (i + 1) + BL - left[i]);
          bus.pod_wr_valid[i] = inj[i] || left[i] > 0;
          bus.pod_wr_addr[i*AW +: AW] = AW'(a);
          bus.pod_wr_data[i*DW +: DW] = DW'({16'hDA7A, a});
          if (left[i] > 0) left[i]--;
          if (bus.pod_wr_ack[i]) begin
            grants.push_back(i);
            gids.push_back(int'(bus.grant_id));
            left[i] = BL;
            if (reqs[i] > 0) reqs[i]--;
          end
          bus.pod_wr_en[i] = reqs[i] > 0;
        end
        wait_c = bus.ram_wr_en ? wait_c + 1 : 0;
        bus.ram_wr_ack = bus.ram_wr_en && wait_c == ack_dly + 1;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear0();
    u[0].beat_a.delete();
    u[0].beat_d.delete();
    u[0].grants.delete();
    u[0].gids.delete();
    u[0].runs.delete();
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_en", u[0].bus.ram_wr_en, 0);
    chk("rst_valid", u[0].bus.ram_wr_valid, 0);
    chk("rst_addr", u[0].bus.ram_wr_addr, 0);
    chk("rst_data", u[0].bus.ram_wr_data, 0);
    chk("rst_pod_ack", u[0].bus.pod_wr_ack, 0);
    chk("rst_gid", u[0].bus.grant_id, 0);
    chk("rst_err", u[0].bus.protocol_err, 0);
    chk("rst_en_4p", u[1].bus.ram_wr_en, 0);
    rst = 1'b0;
    tick(2);
    // single pod, RAM ack on the 4th REQ cycle
    u[0].ack_dly = 3;
    u[0].reqs[0] = 1;
    tick();
    chk("sel_pre", u[0].bus.ram_wr_en, 0);
    tick();
    chk("sel_n1", u[0].bus.ram_wr_en, 1);
    tick(3);
    chk("ram_ack", u[0].bus.ram_wr_ack, 1);
    chk("pod_ack_early", u[0].bus.pod_wr_ack, 0);
    tick();
    chk("pod_ack", u[0].bus.pod_wr_ack, 2'b01);
    chk("en_drop", u[0].bus.ram_wr_en, 0);
    tick();
    chk("ack_pulse", u[0].bus.pod_wr_ack, 0);
    chk("fwd_lat", u[0].bus.ram_wr_valid, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("beat_v", u[0].bus.ram_wr_valid, 1);
      chk("beat_a", u[0].bus.ram_wr_addr, 128'(32'h100 + b));
      chk("beat_d", u[0].bus.ram_wr_data, 128'({16'hDA7A, 32'(32'h100 + b)}));
    end
    tick();
    chk("post_v", u[0].bus.ram_wr_valid, 0);
    // contention from a fresh rr pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    clear0();
    u[0].ack_dly = 1;
    u[0].reqs[0] = 4;
    u[0].reqs[1] = 4;
    for (int t = 0; t < 600 && u[0].runs.size() < 8; t++) tick();
    chk("cont_bursts", u[0].runs.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("cont_grant", u[0].grants[k], k % 2);
      chk("cont_gid", u[0].gids[k], k % 2);
      chk("cont_len", u[0].runs[k], 4);
      chk("cont_addr", u[0].beat_a[k*4+3], 128'(32'h100 * (k % 2 + 1) + 3));
    end
    // mask, then ram_ready
    clear0();
    u[0].bus.pod_enable = 2'b01;
    u[0].reqs[1] = 1;
    tick(20);
    chk("mask_grants", u[0].grants.size(), 0);
    chk("mask_en", u[0].bus.ram_wr_en, 0);
    u[0].bus.ram_ready = 1'b0;
    u[0].bus.pod_enable = 2'b11;
    tick(10);
    chk("nrdy_en", u[0].bus.ram_wr_en, 0);
    chk("nrdy_grants", u[0].grants.size(), 0);
    u[0].bus.ram_ready = 1'b1;
    tick();
    chk("rdy_en", u[0].bus.ram_wr_en, 1);
    chk("rdy_gid", u[0].bus.grant_id, 1);
    for (int t = 0; t < 100 && u[0].runs.size() < 1; t++) tick();
    chk("rdy_grant", u[0].grants.size() == 1 && u[0].grants[0] == 1, 1);
    // protocol error from the non-owning pod
    clear0();
    u[0].ack_dly = 0;
    u[0].reqs[0] = 1;
    for (int t = 0; t < 100 && !u[0].bus.pod_wr_ack[0]; t++) tick();
    chk("perr_ack", u[0].bus.pod_wr_ack, 2'b01);
    u[0].inj = 2'b10;
    tick();
    u[0].inj = 2'b00;
    tick();
    chk("perr_set", u[0].bus.protocol_err, 2'b10);
    for (int t = 0; t < 100 && u[0].runs.size() < 1; t++) tick();
    tick(3);
    chk("perr_sticky", u[0].bus.protocol_err, 2'b10);
    chk("perr_beats", u[0].beat_a.size(), 4);
    for (int b = 0; b < 4; b++) chk("perr_addr", u[0].beat_a[b], 128'(32'h100 + b));
    u[0].inj = 2'b01;
    tick();
    u[0].inj = 2'b00;
    tick();
    chk("perr_idle", u[0].bus.protocol_err, 2'b11);
    chk("perr_drop", u[0].beat_a.size(), 4);
    // reset mid-burst
    clear0();
    u[0].reqs[0] = 1;
    for (int t = 0; t < 100 && u[0].beat_a.size() < 2; t++) tick();
    rst = 1'b1;
    #1;
    chk("mid_valid", u[0].bus.ram_wr_valid, 0);
    chk("mid_addr", u[0].bus.ram_wr_addr, 0);
    chk("mid_data", u[0].bus.ram_wr_data, 0);
    chk("mid_err", u[0].bus.protocol_err, 0);
    chk("mid_en", u[0].bus.ram_wr_en, 0);
    chk("mid_gid", u[0].bus.grant_id, 0);
    tick(6);
    rst = 1'b0;
    tick();
    clear0();
    u[0].reqs[0] = 1;
    for (int t = 0; t < 100 && u[0].runs.size() < 1; t++) tick();
    chk("fresh_len", u[0].runs.size() == 1 ? u[0].runs[0] : -1, 4);
    chk("fresh_grant", u[0].grants.size() == 1 && u[0].grants[0] == 0, 1);
    for (int b = 0; b < 4; b++) chk("fresh_addr", u[0].beat_a[b], 128'(32'h100 + b));
    chk("fresh_err", u[0].bus.protocol_err, 0);
    // four pods, eight-beat bursts
    u[1].ack_dly = 2;
    u[1].reqs[0] = 2;
    u[1].reqs[1] = 1;
    u[1].reqs[2] = 1;
    u[1].reqs[3] = 1;
    for (int t = 0; t < 800 && u[1].runs.size() < 5; t++) tick();
    chk("p4_bursts", u[1].runs.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("p4_grant", u[1].grants[k], exp_g[k]);
      chk("p4_gid", u[1].gids[k], exp_g[k]);
      chk("p4_len", u[1].runs[k], 8);
      for (int b = 0; b < 8; b++) chk("p4_addr", u[1].beat_a[k*8+b], 128'(32'h100 * (exp_g[k] + 1) + b));
    end
    chk("p4_err", u[1].bus.protocol_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
